// File: rtl/verin_pkg.sv
// rtl/verin_pkg.sv - shared encodings for the verin direction/PWM controller
package verin_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DEAD = 2'd2
   } state_t;

   localparam logic [1:0] ADDR_CTRL     = 2'd0;
   localparam logic [1:0] ADDR_DUTY     = 2'd1;
   localparam logic [1:0] ADDR_DEADTIME = 2'd2;
   localparam logic [1:0] ADDR_STATUS   = 2'd3;

   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_SENS   = 1;
   localparam int STATUS_FLAG = 4;

endpackage

// File: rtl/verin_pwm_gen.sv
// rtl/verin_pwm_gen.sv - PWM period counter with duty shadow reloaded only at period wrap
module verin_pwm_gen #(
   parameter int PERIOD = 2000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        run,
   input  logic        inhibit,
   input  logic [15:0] duty,
   output logic        pwm
);

   localparam int CW = $clog2(PERIOD);

   logic [CW-1:0] cnt;
   logic [15:0]   duty_act;
   logic          wrap;

   assign wrap = (cnt == CW'(PERIOD - 1));

   // Outside RUN the shadow tracks DUTY, so it holds the current value on RUN entry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt      <= '0;
         duty_act <= '0;
         pwm      <= 1'b0;
      end else begin
         if (!run || wrap) begin
            cnt      <= '0;
            duty_act <= duty;
         end else begin
            cnt <= cnt + CW'(1);
         end
         pwm <= run & ~inhibit & (32'(cnt) < 32'(duty_act));
      end
   end

endmodule

// File: rtl/verin_sens_ctrl.sv
// rtl/verin_sens_ctrl.sv - Avalon-MM actuator controller: registers, reversal FSM, dead time
// Optional end-of-travel protection is built when VERIN_ENDSTOP_EN is defined.
module verin_sens_ctrl import verin_pkg::*; #(
   parameter int PERIOD       = 2000,
   parameter int DT_BITS      = 16,
   parameter int DEADTIME_RST = 500
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        endstop_fwd,
   input  logic        endstop_rev,
   output logic        sens_out,
   output logic        pwm_out
);

   logic [1:0]         ctrl;
   logic [15:0]        duty;
   logic [DT_BITS-1:0] deadtime;
   logic [DT_BITS-1:0] dt;
   state_t             state, state_nxt;
   logic               sens_nxt, dt_load;
   logic               wr_en, enable, sens_req;
   logic               inhibit, flag;
   logic               unused_wdata;

   assign wr_en        = chipselect & ~write_n;
   assign enable       = ctrl[CTRL_ENABLE];
   assign sens_req     = ctrl[CTRL_SENS];
   assign unused_wdata = ^writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl     <= '0;
         duty     <= '0;
         deadtime <= DT_BITS'(DEADTIME_RST);
      end else if (wr_en) begin
         case (address)
            ADDR_CTRL:     ctrl     <= writedata[1:0];
            ADDR_DUTY:     duty     <= writedata[15:0];
            ADDR_DEADTIME: deadtime <= writedata[DT_BITS-1:0];
            default:       ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      sens_nxt  = sens_out;
      dt_load   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable) begin
               if (sens_req == sens_out) begin
                  state_nxt = ST_RUN;
               end else begin
                  state_nxt = ST_DEAD;
                  dt_load   = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (!enable) begin
               state_nxt = ST_IDLE;
            end else if (sens_req != sens_out) begin
               state_nxt = ST_DEAD;
               dt_load   = 1'b1;
            end
         end
         ST_DEAD: begin
            if (!enable) begin
               state_nxt = ST_IDLE;
            end else if (dt == '0) begin
               sens_nxt  = sens_req;
               state_nxt = ST_RUN;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         sens_out <= 1'b0;
         dt       <= '0;
      end else begin
         state    <= state_nxt;
         sens_out <= sens_nxt;
         if (dt_load) begin
            dt <= deadtime;
         end else if (state == ST_DEAD && dt != '0) begin
            dt <= dt - DT_BITS'(1);
         end
      end
   end

`ifdef VERIN_ENDSTOP_EN
   logic [1:0] fwd_sync, rev_sync;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fwd_sync <= '0;
         rev_sync <= '0;
         flag     <= 1'b0;
      end else begin
         fwd_sync <= {fwd_sync[0], endstop_fwd};
         rev_sync <= {rev_sync[0], endstop_rev};
         if (inhibit) begin
            flag <= 1'b1;
         end else if (wr_en && address == ADDR_STATUS && writedata[STATUS_FLAG]) begin
            flag <= 1'b0;
         end
      end
   end

   assign inhibit = (state == ST_RUN) & (sens_out ? fwd_sync[1] : rev_sync[1]);
`else
   logic unused_endstop;
   assign unused_endstop = endstop_fwd ^ endstop_rev;
   assign inhibit        = 1'b0;
   assign flag           = 1'b0;
`endif

   // Gating with the next state drops PWM on the very edge a reversal or disable is decided.
   verin_pwm_gen #(.PERIOD(PERIOD)) u_pwm (
      .clk     (clk),
      .reset_n (reset_n),
      .run     ((state == ST_RUN) && (state_nxt == ST_RUN)),
      .inhibit (inhibit),
      .duty    (duty),
      .pwm     (pwm_out)
   );

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_CTRL:     readdata[1:0]         = ctrl;
         ADDR_DUTY:     readdata[15:0]        = duty;
         ADDR_DEADTIME: readdata[DT_BITS-1:0] = deadtime;
         ADDR_STATUS:   readdata[4:0]         = {flag, pwm_out, sens_out, state};
         default:       readdata              = '0;
      endcase
   end

endmodule

// File: tb/tb_verin_sens_ctrl.sv
// tb/tb_verin_sens_ctrl.sv - directed self-checking bench for verin_sens_ctrl
module tb_verin_sens_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        endstop_fwd;
   logic        endstop_rev;
   logic        sens_out;
   logic        pwm_out;

   int n_vec = 0;
   int n_err = 0;
   int c;
   logic [31:0] d;

   always #5 clk = ~clk;

   verin_sens_ctrl dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .address     (address),
      .chipselect  (chipselect),
      .write_n     (write_n),
      .writedata   (writedata),
      .readdata    (readdata),
      .endstop_fwd (endstop_fwd),
      .endstop_rev (endstop_rev),
      .sens_out    (sens_out),
      .pwm_out     (pwm_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] v);
      address    = a;
      writedata  = v;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] v);
      address = a;
      #1;
      v = readdata;
   endtask

   task automatic count_high(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         if (pwm_out === 1'b1) cnt++;
         @(negedge clk);
      end
   endtask

   task automatic count_dead(output int cnt);
      logic [31:0] s;
      cnt = 0;
      rd(2'd3, s);
      while (s[1:0] == 2'd2 && cnt < 300) begin
         cnt++;
         @(negedge clk);
         rd(2'd3, s);
      end
   endtask

   initial begin
      reset_n     = 1'b0;
      address     = 2'd0;
      chipselect  = 1'b0;
      write_n     = 1'b1;
      writedata   = '0;
      endstop_fwd = 1'b0;
      endstop_rev = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_sens", 32'(sens_out), 0);
      chk("rst_pwm", 32'(pwm_out), 0);
      rd(2'd3, d); chk("rst_status", d, 32'h0);
      rd(2'd2, d); chk("rst_deadtime", d, 32'd500);
      rd(2'd0, d); chk("rst_ctrl", d, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // DUTY=500 start-up latency and duty
      wr(2'd1, 32'd500);
      wr(2'd0, 32'h1);
      chk("start_n0_pwm", 32'(pwm_out), 0);
      @(negedge clk);
      rd(2'd3, d); chk("start_n1_status", d, 32'h1);
      @(negedge clk);
      chk("start_n2_pwm", 32'(pwm_out), 1);
      count_high(2000, c); chk("duty500_period", 32'(c), 500);
      chk("duty500_sens", 32'(sens_out), 0);

      // Mid-period DUTY change takes effect only after the wrap
      wr(2'd1, 32'd1500);
      count_high(1999, c); chk("duty_old_until_wrap", 32'(c), 499);
      count_high(2000, c); chk("duty1500_period", 32'(c), 1500);

      // Reversal with DEADTIME=100
      wr(2'd2, 32'd100);
      wr(2'd0, 32'h3);
      @(negedge clk);
      chk("rev_pwm_off", 32'(pwm_out), 0);
      count_dead(c); chk("rev_dead_cycles", 32'(c), 101);
      chk("rev_sens", 32'(sens_out), 1);
      rd(2'd3, d); chk("rev_exit_status", d, 32'h5);
      @(negedge clk);
      chk("rev_restart_pwm", 32'(pwm_out), 1);

      // Zero-extended DUTY readback
      wr(2'd1, 32'hABCD_1234);
      rd(2'd1, d); chk("duty_readback", d, 32'h1234);

      // Boundary duties, reloaded through IDLE->RUN
      wr(2'd0, 32'h2); wr(2'd1, 32'd0); wr(2'd0, 32'h3);
      repeat (2) @(negedge clk);
      count_high(2000, c); chk("duty0_const", 32'(c), 0);
      wr(2'd0, 32'h2); wr(2'd1, 32'd2000); wr(2'd0, 32'h3);
      repeat (2) @(negedge clk);
      count_high(2000, c); chk("duty2000_const", 32'(c), 2000);
      wr(2'd0, 32'h2); wr(2'd1, 32'hFFFF); wr(2'd0, 32'h3);
      repeat (2) @(negedge clk);
      count_high(2000, c); chk("dutyffff_const", 32'(c), 2000);

`ifdef VERIN_ENDSTOP_EN
      endstop_fwd = 1'b1;
      repeat (3) @(negedge clk);
      chk("es_pwm_off", 32'(pwm_out), 0);
      rd(2'd3, d); chk("es_flag_set", 32'(d[4]), 1);
      endstop_fwd = 1'b0;
      repeat (3) @(negedge clk);
      rd(2'd3, d); chk("es_flag_sticky", 32'(d[4]), 1);
      wr(2'd3, 32'h10);
      rd(2'd3, d); chk("es_flag_clear", 32'(d[4]), 0);
      @(negedge clk);
      chk("es_pwm_back", 32'(pwm_out), 1);
`else
      endstop_fwd = 1'b1;
      repeat (3) @(negedge clk);
      chk("es_ignored_pwm", 32'(pwm_out), 1);
      wr(2'd3, 32'h10);
      rd(2'd3, d); chk("es_ignored_status", d, 32'hD);
      endstop_fwd = 1'b0;
`endif

      // Disable during DEAD: back to IDLE, direction kept
      wr(2'd0, 32'h1);
      repeat (3) @(negedge clk);
      wr(2'd0, 32'h0);
      rd(2'd3, d); chk("abort_still_dead", d, 32'h6);
      @(negedge clk);
      rd(2'd3, d); chk("abort_idle", d, 32'h4);

      // DEADTIME=0: a single DEAD cycle
      wr(2'd2, 32'd0);
      wr(2'd0, 32'h1);
      @(negedge clk);
      count_dead(c); chk("dt0_dead_cycles", 32'(c), 1);
      rd(2'd3, d); chk("dt0_exit_status", d, 32'h1);
      @(negedge clk);
      chk("dt0_pwm_on", 32'(pwm_out), 1);

      // Asynchronous reset mid-RUN
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_sens", 32'(sens_out), 0);
      chk("arst_pwm", 32'(pwm_out), 0);
      rd(2'd3, d); chk("arst_status", d, 32'h0);
      rd(2'd2, d); chk("arst_deadtime", d, 32'd500);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
